// File: rtl/span_filler.sv
// span_filler: queued rectangle filler that turns span-over-rows commands into masked word writes.
// Optional build macro: SPAN_FILLER_WRITETHROUGH_EN enables the single-entry write-through path.
module span_filler #(
    parameter int FB_WIDTH  = 480,
    parameter int FB_ADDR_W = 16,
    parameter int CMD_DEPTH = 4,
    parameter int ROWS_W    = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 avs_slave_write,
    input  logic [16:0]          avs_slave_address,
    input  logic [31:0]          avs_slave_writedata,
    input  logic [3:0]           avs_slave_byteenable,
    output logic                 avs_slave_waitrequest,
    output logic                 avm_fbuff_write,
    output logic [FB_ADDR_W-1:0] avm_fbuff_address,
    output logic [31:0]          avm_fbuff_writedata,
    output logic [3:0]           avm_fbuff_byteenable,
    input  logic                 avm_fbuff_waitrequest,
    output logic                 busy
);
    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int RB_W  = FB_ADDR_W - 1;
    localparam int WPR   = FB_WIDTH / 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2
    } state_t;

    typedef struct packed {
        logic              fb_sel;
        logic [ROWS_W-1:0] rows;
        logic [8:0]        y;
        logic [8:0]        left;
        logic [8:0]        right;
        logic [7:0]        colour;
    } cmd_t;

    state_t             state_r;
    state_t             state_n;
    cmd_t               fifo_mem_r [CMD_DEPTH];
    cmd_t               cmd_r;
    cmd_t               cmd_in_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_n;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic [8:0]         curr_r;
    logic [8:0]         ptr_curr_s;
    logic [8:0]         right_c_s;
    logic [RB_W-1:0]    rowbase_r;
    logic [RB_W-1:0]    ptr_rowbase_s;
    logic [RB_W-1:0]    rb_init_s;
    logic [ROWS_W-1:0]  rows_r;
    logic [ROWS_W-1:0]  ptr_rows_s;
    logic               out_wt_r;
    logic               beat_done_s;
    logic               slot_free_s;
    logic               fill_done_s;
    logic               fill_beat_s;
    logic               cmd_valid_s;

    function automatic logic [8:0] clamp_right(input logic [8:0] r);
        if ({1'b0, r} >= 10'(FB_WIDTH)) begin
            return 9'(FB_WIDTH - 1);
        end else begin
            return r;
        end
    endfunction

    // Lanes from the current pixel up to the span end, capped at the word end.
    function automatic logic [3:0] beat_be(input logic [8:0] curr, input logic [8:0] right);
        logic [1:0] hi;
        logic [3:0] be;
        hi = (curr[8:2] == right[8:2]) ? right[1:0] : 2'd3;
        be = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            be[i] = (2'(i) >= curr[1:0]) && (2'(i) <= hi);
        end
        return be;
    endfunction

    assign cmd_in_s.fb_sel = avs_slave_address[15];
    assign cmd_in_s.rows   = avs_slave_address[9 +: ROWS_W];
    assign cmd_in_s.y      = avs_slave_address[8:0];
    assign cmd_in_s.left   = avs_slave_writedata[8:0];
    assign cmd_in_s.right  = avs_slave_writedata[17:9];
    assign cmd_in_s.colour = avs_slave_writedata[25:18];

    assign full_s      = (count_r == CNT_W'(CMD_DEPTH));
    assign push_s      = avs_slave_write & ~avs_slave_waitrequest & ~avs_slave_address[16];
    assign pop_s       = (state_r == IDLE) && (count_r != '0);
    assign beat_done_s = avm_fbuff_write & ~avm_fbuff_waitrequest;
    assign slot_free_s = ~avm_fbuff_write | beat_done_s;
    assign fill_done_s = (state_r == FILL) && beat_done_s && !out_wt_r;
    assign right_c_s   = clamp_right(cmd_r.right);
    assign cmd_valid_s = (cmd_r.left <= cmd_r.right) && ({1'b0, cmd_r.left} < 10'(FB_WIDTH));
    assign rb_init_s   = RB_W'(32'(cmd_r.y) * 32'(WPR));

    // FIFO occupancy after this cycle's push and pop.
    always_comb begin
        count_n = count_r;
        case ({push_s, pop_s})
            2'b10:   count_n = count_r + CNT_W'(1);
            2'b01:   count_n = count_r - CNT_W'(1);
            default: count_n = count_r;
        endcase
    end

    // Command FIFO storage and pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= cmd_in_s;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_n;
        end
    end

    // Next state and next fill pointer; the pointer always names the next fill beat owed.
    always_comb begin
        state_n       = state_r;
        ptr_curr_s    = curr_r;
        ptr_rowbase_s = rowbase_r;
        ptr_rows_s    = rows_r;
        fill_beat_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_r != '0) begin
                    state_n = LOAD;
                end else begin
                    state_n = IDLE;
                end
            end
            LOAD: begin
                if (cmd_valid_s) begin
                    state_n       = FILL;
                    ptr_curr_s    = cmd_r.left;
                    ptr_rowbase_s = rb_init_s;
                    ptr_rows_s    = cmd_r.rows;
                    fill_beat_s   = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            FILL: begin
                fill_beat_s = 1'b1;
                if (fill_done_s) begin
                    if (curr_r[8:2] == right_c_s[8:2]) begin
                        if (rows_r != '0) begin
                            ptr_rows_s    = rows_r - ROWS_W'(1);
                            ptr_rowbase_s = rowbase_r + RB_W'(WPR);
                            ptr_curr_s    = cmd_r.left;
                        end else begin
                            state_n     = IDLE;
                            fill_beat_s = 1'b0;
                        end
                    end else begin
                        ptr_curr_s = {curr_r[8:2] + 7'd1, 2'b00};
                    end
                end else begin
                    ptr_curr_s = curr_r;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef SPAN_FILLER_WRITETHROUGH_EN
    logic                 wt_valid_r;
    logic [FB_ADDR_W-1:0] wt_addr_r;
    logic [31:0]          wt_data_r;
    logic [3:0]           wt_be_r;
    logic                 wt_push_s;
    logic                 wt_issue_s;

    assign wt_push_s             = avs_slave_write & ~avs_slave_waitrequest & avs_slave_address[16];
    assign wt_issue_s            = slot_free_s & wt_valid_r;
    assign avs_slave_waitrequest = full_s | wt_valid_r;

    // Single-entry write-through holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wt_valid_r <= 1'b0;
            wt_addr_r  <= '0;
            wt_data_r  <= '0;
            wt_be_r    <= '0;
        end else if (wt_push_s) begin
            wt_valid_r <= 1'b1;
            wt_addr_r  <= FB_ADDR_W'(avs_slave_address[15:0]);
            wt_data_r  <= avs_slave_writedata;
            wt_be_r    <= avs_slave_byteenable;
        end else if (wt_issue_s) begin
            wt_valid_r <= 1'b0;
        end
    end
`else
    logic unused_s;
    assign unused_s              = ^{avs_slave_writedata[31:26], avs_slave_byteenable};
    assign avs_slave_waitrequest = full_s;
`endif

    // FSM state, fill pointer and registered master beat; a beat only changes at a free slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r              <= IDLE;
            cmd_r                <= '0;
            curr_r               <= '0;
            rowbase_r            <= '0;
            rows_r               <= '0;
            out_wt_r             <= 1'b0;
            avm_fbuff_write      <= 1'b0;
            avm_fbuff_address    <= '0;
            avm_fbuff_writedata  <= '0;
            avm_fbuff_byteenable <= '0;
            busy                 <= 1'b0;
        end else begin
            state_r   <= state_n;
            curr_r    <= ptr_curr_s;
            rowbase_r <= ptr_rowbase_s;
            rows_r    <= ptr_rows_s;
            busy      <= (count_n != '0) || (state_n != IDLE);
            if (pop_s) begin
                cmd_r <= fifo_mem_r[rd_ptr_r];
            end
            if (slot_free_s) begin
`ifdef SPAN_FILLER_WRITETHROUGH_EN
                if (wt_valid_r) begin
                    avm_fbuff_write      <= 1'b1;
                    avm_fbuff_address    <= wt_addr_r;
                    avm_fbuff_writedata  <= wt_data_r;
                    avm_fbuff_byteenable <= wt_be_r;
                    out_wt_r             <= 1'b1;
                end else
`endif
                if (fill_beat_s) begin
                    avm_fbuff_write      <= 1'b1;
                    avm_fbuff_address    <= {cmd_r.fb_sel, ptr_rowbase_s + RB_W'(ptr_curr_s[8:2])};
                    avm_fbuff_writedata  <= {4{cmd_r.colour}};
                    avm_fbuff_byteenable <= beat_be(ptr_curr_s, right_c_s);
                    out_wt_r             <= 1'b0;
                end else begin
                    avm_fbuff_write <= 1'b0;
                    out_wt_r        <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_span_filler.sv
// Directed bench for span_filler: expected beats are hand-computed constants.
module tb_span_filler;
    logic        clk = 1'b0;
    logic        reset;
    logic        avs_write;
    logic [16:0] avs_addr;
    logic [31:0] avs_data;
    logic [3:0]  avs_be;
    logic        avs_wait;
    logic        avm_write;
    logic [15:0] avm_addr;
    logic [31:0] avm_data;
    logic [3:0]  avm_be;
    logic        avm_wait;
    logic        busy;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        int          cyc;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    span_filler dut (
        .clk                   (clk),
        .reset                 (reset),
        .avs_slave_write       (avs_write),
        .avs_slave_address     (avs_addr),
        .avs_slave_writedata   (avs_data),
        .avs_slave_byteenable  (avs_be),
        .avs_slave_waitrequest (avs_wait),
        .avm_fbuff_write       (avm_write),
        .avm_fbuff_address     (avm_addr),
        .avm_fbuff_writedata   (avm_data),
        .avm_fbuff_byteenable  (avm_be),
        .avm_fbuff_waitrequest (avm_wait),
        .busy                  (busy)
    );

    // Log every beat that completes at the coming rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!reset && avm_write && !avm_wait) begin
            got_q.push_back('{avm_addr, avm_data, avm_be, cyc});
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic add_exp(input logic [15:0] a, input logic [7:0] col, input logic [3:0] be);
        exp_q.push_back('{a, {4{col}}, be, 0});
    endtask

    task automatic compare_beats(input string tag);
        check_value({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_value($sformatf("%s_addr%0d", tag, i), 32'(got_q[i].a), 32'(exp_q[i].a));
            check_value($sformatf("%s_data%0d", tag, i), got_q[i].d, exp_q[i].d);
            check_value($sformatf("%s_be%0d", tag, i), 32'(got_q[i].be), 32'(exp_q[i].be));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic push(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be);
        int n = 0;
        avs_write = 1'b1;
        avs_addr  = a;
        avs_data  = d;
        avs_be    = be;
        @(negedge clk);
        while (avs_wait && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_value("push_timeout", 32'(n >= 300), 32'd0);
        @(posedge clk);
        #1;
        avs_write = 1'b0;
    endtask

    task automatic cmd(input logic fb, input int rows_m1, input int y, input int l, input int r,
                       input logic [7:0] col);
        push({1'b0, fb, 6'(rows_m1), 9'(y)}, {6'b0, col, 9'(r), 9'(l)}, 4'hF);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((busy || avm_write) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_idle_timeout"}, 32'(n >= 1000), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_write(input string tag);
        int n = 0;
        @(negedge clk);
        while (!avm_write && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_write_timeout"}, 32'(n >= 50), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        avs_write = 1'b0;
        avs_addr  = '0;
        avs_data  = '0;
        avs_be    = '0;
        avm_wait  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_value("rst_write", 32'(avm_write), 32'd0);
        check_value("rst_addr", 32'(avm_addr), 32'd0);
        check_value("rst_data", avm_data, 32'd0);
        check_value("rst_be", 32'(avm_be), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_wait", 32'(avs_wait), 32'd0);
        @(posedge clk);
        #1;

        // Single row, two partial words
        cmd(1'b0, 0, 10, 5, 9, 8'hAB);
        add_exp(16'd1201, 8'hAB, 4'b1110);
        add_exp(16'd1202, 8'hAB, 4'b0011);
        wait_idle("t1");
        compare_beats("t1");

        // Three rows on buffer 1, no bubbles between beats
        cmd(1'b1, 2, 10, 5, 9, 8'hAB);
        wait_idle("t2");
        for (int i = 1; i < got_q.size(); i++) begin
            check_value($sformatf("t2_gap%0d", i), 32'(got_q[i].cyc - got_q[i-1].cyc), 32'd1);
        end
        add_exp(16'h8000 | 16'd1201, 8'hAB, 4'b1110);
        add_exp(16'h8000 | 16'd1202, 8'hAB, 4'b0011);
        add_exp(16'h8000 | 16'd1321, 8'hAB, 4'b1110);
        add_exp(16'h8000 | 16'd1322, 8'hAB, 4'b0011);
        add_exp(16'h8000 | 16'd1441, 8'hAB, 4'b1110);
        add_exp(16'h8000 | 16'd1442, 8'hAB, 4'b0011);
        compare_beats("t2");

        // Stall beat 2 for three cycles
        cmd(1'b0, 0, 10, 5, 9, 8'hAB);
        wait_write("t3");
        @(posedge clk);
        #1;
        avm_wait = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_value("t3_hold_write", 32'(avm_write), 32'd1);
            check_value("t3_hold_addr", 32'(avm_addr), 32'd1202);
            check_value("t3_hold_data", avm_data, 32'hABABABAB);
            check_value("t3_hold_be", 32'(avm_be), 32'b0011);
            @(posedge clk);
        end
        #1;
        avm_wait = 1'b0;
        wait_idle("t3");
        add_exp(16'd1201, 8'hAB, 4'b1110);
        add_exp(16'd1202, 8'hAB, 4'b0011);
        compare_beats("t3");

        // Fill the FIFO while the master stalls; all commands run in order
        avm_wait = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cmd(1'b0, 0, k, 0, 3, 8'(k));
        end
        @(negedge clk);
        check_value("t4_full_wait", 32'(avs_wait), 32'd1);
        @(posedge clk);
        #1;
        fork
            cmd(1'b0, 0, 6, 0, 3, 8'd6);
            begin
                repeat (3) @(negedge clk);
                check_value("t4_still_wait", 32'(avs_wait), 32'd1);
                @(posedge clk);
                #1;
                avm_wait = 1'b0;
            end
        join
        wait_idle("t4");
        for (int k = 1; k <= 6; k++) begin
            add_exp(16'(k * 120), 8'(k), 4'b1111);
        end
        compare_beats("t4");

        // Rejected commands: left > right, and left beyond the row
        cmd(1'b0, 0, 5, 20, 3, 8'h99);
        n = 0;
        @(negedge clk);
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_value("t5_busy_clear", 32'(n <= 3), 32'd1);
        @(posedge clk);
        #1;
        cmd(1'b0, 0, 5, 480, 500, 8'h99);
        wait_idle("t5b");
        compare_beats("t5");

        // Right edge clamped to the last pixel of the row
        cmd(1'b0, 0, 0, 470, 500, 8'h33);
        add_exp(16'd117, 8'h33, 4'b1100);
        add_exp(16'd118, 8'h33, 4'b1111);
        add_exp(16'd119, 8'h33, 4'b1111);
        wait_idle("t6");
        compare_beats("t6");

        // Row base wraps inside buffer 1; buffer bit unchanged
        cmd(1'b1, 1, 273, 0, 3, 8'h77);
        add_exp(16'hFFF8, 8'h77, 4'b1111);
        add_exp(16'h8070, 8'h77, 4'b1111);
        wait_idle("t7");
        compare_beats("t7");

        // Back-to-back commands: IDLE + LOAD between last and first beat
        cmd(1'b0, 0, 20, 0, 3, 8'h11);
        cmd(1'b0, 0, 21, 0, 3, 8'h22);
        wait_idle("t8");
        check_value("t8_gap", (got_q.size() >= 2) ? 32'(got_q[1].cyc - got_q[0].cyc) : 32'hFFFFFFFF, 32'd3);
        add_exp(16'd2400, 8'h11, 4'b1111);
        add_exp(16'd2520, 8'h22, 4'b1111);
        compare_beats("t8");

        // Write-through pushed while fill beat 1 is stalled
        avm_wait = 1'b1;
        cmd(1'b0, 0, 1, 2, 13, 8'h5A);
        push({1'b1, 16'h1234}, 32'hDEADBEEF, 4'b0101);
        wait_write("t9");
        @(posedge clk);
        #1;
        avm_wait = 1'b0;
        wait_idle("t9");
        add_exp(16'd120, 8'h5A, 4'b1100);
`ifdef SPAN_FILLER_WRITETHROUGH_EN
        exp_q.push_back('{16'h1234, 32'hDEADBEEF, 4'b0101, 0});
`endif
        add_exp(16'd121, 8'h5A, 4'b1111);
        add_exp(16'd122, 8'h5A, 4'b1111);
        add_exp(16'd123, 8'h5A, 4'b0011);
        compare_beats("t9");

        // Lone write-through with the FSM idle
        push({1'b1, 16'h0042}, 32'h01020304, 4'b1000);
        wait_idle("t10");
`ifdef SPAN_FILLER_WRITETHROUGH_EN
        exp_q.push_back('{16'h0042, 32'h01020304, 4'b1000, 0});
`endif
        compare_beats("t10");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
